// File: rtl/seq_alu_if.sv
// seq_alu_if: request/result bundle between the EX-stage control and seq_alu.
// Revision 1.0 - initial release
`default_nettype none

interface seq_alu_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ctr;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_hi;
  logic             iszero;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, ctr, input1, input2,
    input  in_ready, out, out_hi, iszero, overflow, busy, done
  );

  modport slave (
    input  in_valid, ctr, input1, input2,
    output in_ready, out, out_hi, iszero, overflow, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/seq_alu.sv
//==============================================================================
// Module      : seq_alu
// Description : Multi-cycle ALU; single-cycle logic/arith/shift ops plus
//               bit-serial unsigned multiply and restoring divide.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  seq_alu_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] c_OP_ADD  = 4'd0;
  localparam logic [3:0] c_OP_SUB  = 4'd1;
  localparam logic [3:0] c_OP_OR   = 4'd2;
  localparam logic [3:0] c_OP_AND  = 4'd3;
  localparam logic [3:0] c_OP_XOR  = 4'd4;
  localparam logic [3:0] c_OP_SLT  = 4'd5;
  localparam logic [3:0] c_OP_SLTU = 4'd6;
  localparam logic [3:0] c_OP_SLL  = 4'd7;
  localparam logic [3:0] c_OP_SRL  = 4'd8;
  localparam logic [3:0] c_OP_SRA  = 4'd9;
  localparam logic [3:0] c_OP_MULU = 4'd10;
  localparam logic [3:0] c_OP_DIVU = 4'd11;

  localparam int               c_CNTW     = SHW + 1;
  localparam logic [c_CNTW-1:0] c_CNT_INIT = c_CNTW'(WIDTH);
  localparam logic [c_CNTW-1:0] c_CNT_LAST = c_CNTW'(1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_opb;
  logic [c_CNTW-1:0]  r_cnt;
  logic               r_is_div;

  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [SHW-1:0]     w_amt;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf;
  logic               w_iter;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH-1:0]   w_div_diff;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_next_hi;
  logic [WIDTH-1:0]   w_next_lo;

  assign bus.in_ready = (r_state != RUN);
  assign w_iter       = (bus.ctr == c_OP_MULU) || (bus.ctr == c_OP_DIVU);

  always_comb begin
    w_sum  = bus.input1 + bus.input2;
    w_diff = bus.input1 - bus.input2;
    w_amt  = bus.input2[SHW-1:0];
    w_res  = '0;
    w_ovf  = 1'b0;
    case (bus.ctr)
      c_OP_ADD: begin
        w_res = w_sum;
        w_ovf = (bus.input1[WIDTH-1] == bus.input2[WIDTH-1]) &&
                (w_sum[WIDTH-1] != bus.input1[WIDTH-1]);
      end
      c_OP_SUB: begin
        w_res = w_diff;
        w_ovf = (bus.input1[WIDTH-1] != bus.input2[WIDTH-1]) &&
                (w_diff[WIDTH-1] != bus.input1[WIDTH-1]);
      end
      c_OP_OR:   w_res = bus.input1 | bus.input2;
      c_OP_AND:  w_res = bus.input1 & bus.input2;
      c_OP_XOR:  w_res = bus.input1 ^ bus.input2;
      c_OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.input1) < $signed(bus.input2))};
      c_OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.input1 < bus.input2)};
      c_OP_SLL:  w_res = bus.input1 << w_amt;
      c_OP_SRL:  w_res = bus.input1 >> w_amt;
      c_OP_SRA:  w_res = $unsigned($signed(bus.input1) >>> w_amt);
      default:   w_res = '0;
    endcase
  end

  // One iteration step: mul shifts {hi,lo} right after a conditional add,
  // div shifts {rem,quo} left and subtracts the divisor when it fits.
  always_comb begin
    w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    w_div_shift = {r_hi, r_lo[WIDTH-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_opb});
    w_div_diff  = w_div_shift[WIDTH-1:0] - r_opb;
    if (r_is_div) begin
      w_next_hi = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
      w_next_lo = {r_lo[WIDTH-2:0], w_div_ge};
    end else begin
      w_next_hi = w_mul_sum[WIDTH:1];
      w_next_lo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_hi         <= '0;
      r_lo         <= '0;
      r_opb        <= '0;
      r_cnt        <= '0;
      r_is_div     <= 1'b0;
      bus.out      <= '0;
      bus.out_hi   <= '0;
      bus.iszero   <= 1'b1;
      bus.overflow <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (r_state)
        RUN: begin
          r_hi  <= w_next_hi;
          r_lo  <= w_next_lo;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == c_CNT_LAST) begin
            bus.out      <= w_next_lo;
            bus.out_hi   <= w_next_hi;
            bus.iszero   <= (w_next_lo == '0);
            bus.overflow <= 1'b0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b1;
            r_state      <= DONE;
          end
        end
        default: begin
          if (bus.in_valid) begin
            if (w_iter) begin
              r_is_div <= (bus.ctr == c_OP_DIVU);
              r_hi     <= '0;
              r_lo     <= (bus.ctr == c_OP_DIVU) ? bus.input1 : bus.input2;
              r_opb    <= (bus.ctr == c_OP_DIVU) ? bus.input2 : bus.input1;
              r_cnt    <= c_CNT_INIT;
              bus.busy <= 1'b1;
              r_state  <= RUN;
            end else begin
              bus.out      <= w_res;
              bus.out_hi   <= '0;
              bus.iszero   <= (w_res == '0);
              bus.overflow <= w_ovf;
              bus.done     <= 1'b1;
              r_state      <= DONE;
            end
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vector table plus hand-written multi-cycle sequences.
// Revision 1.0 - initial release
`default_nettype none

module tb_seq_alu;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_alu_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

  seq_alu #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic [31:0] hi;
    logic        ovf;
    logic        z;
    int          lat;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request and return the number of negedges until done is seen.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(negedge clk);
    chk("in_ready_before_issue", {63'd0, bus.in_ready}, 64'd1);
    bus.ctr      = c;
    bus.input1   = a;
    bus.input2   = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.done && lat < 100);
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int nr_cnt;
    int n;
    int done_seen;

    checks = 0;
    errors = 0;

    vecs[0]  = '{4'd0,  32'h7FFFFFFF, 32'd1,        32'h80000000, 32'd0,        1'b1, 1'b0, 1};
    vecs[1]  = '{4'd1,  32'd5,        32'd5,        32'd0,        32'd0,        1'b0, 1'b1, 1};
    vecs[2]  = '{4'd1,  32'h80000000, 32'd1,        32'h7FFFFFFF, 32'd0,        1'b1, 1'b0, 1};
    vecs[3]  = '{4'd2,  32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 32'd0,        1'b0, 1'b0, 1};
    vecs[4]  = '{4'd3,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 32'd0,        1'b0, 1'b0, 1};
    vecs[5]  = '{4'd4,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 32'd0,        1'b0, 1'b0, 1};
    vecs[6]  = '{4'd5,  32'hFFFFFFFF, 32'd1,        32'd1,        32'd0,        1'b0, 1'b0, 1};
    vecs[7]  = '{4'd6,  32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        1'b0, 1'b1, 1};
    vecs[8]  = '{4'd7,  32'd1,        32'd31,       32'h80000000, 32'd0,        1'b0, 1'b0, 1};
    vecs[9]  = '{4'd7,  32'd1,        32'h23,       32'd8,        32'd0,        1'b0, 1'b0, 1};
    vecs[10] = '{4'd8,  32'h80000000, 32'd4,        32'h08000000, 32'd0,        1'b0, 1'b0, 1};
    vecs[11] = '{4'd9,  32'h80000000, 32'd4,        32'hF8000000, 32'd0,        1'b0, 1'b0, 1};
    vecs[12] = '{4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 33};
    vecs[13] = '{4'd10, 32'h12345678, 32'h10,       32'h23456780, 32'h1,        1'b0, 1'b0, 33};
    vecs[14] = '{4'd11, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 33};
    vecs[15] = '{4'd11, 32'd9,        32'd0,        32'hFFFFFFFF, 32'd9,        1'b0, 1'b0, 33};
    vecs[16] = '{4'd0,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 32'd0,        1'b1, 1'b0, 1};
    vecs[17] = '{4'd13, 32'd5,        32'd6,        32'd0,        32'd0,        1'b0, 1'b1, 1};
    vecs[18] = '{4'd10, 32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 1'b1, 33};
    vecs[19] = '{4'd0,  32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        1'b0, 1'b1, 1};
    vecs[20] = '{4'd11, 32'hFFFFFFFF, 32'd10,       32'h19999999, 32'd5,        1'b0, 1'b0, 33};

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.ctr      = 4'd0;
    bus.input1   = '0;
    bus.input2   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out",      {32'd0, bus.out},      64'd0);
    chk("reset_out_hi",   {32'd0, bus.out_hi},   64'd0);
    chk("reset_iszero",   {63'd0, bus.iszero},   64'd1);
    chk("reset_overflow", {63'd0, bus.overflow}, 64'd0);
    chk("reset_busy",     {63'd0, bus.busy},     64'd0);
    chk("reset_done",     {63'd0, bus.done},     64'd0);
    chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].ctr, vecs[i].a, vecs[i].b, lat);
      chk($sformatf("vec%0d_latency", i),  lat,                      vecs[i].lat);
      chk($sformatf("vec%0d_out", i),      {32'd0, bus.out},         {32'd0, vecs[i].out});
      chk($sformatf("vec%0d_out_hi", i),   {32'd0, bus.out_hi},      {32'd0, vecs[i].hi});
      chk($sformatf("vec%0d_overflow", i), {63'd0, bus.overflow},    {63'd0, vecs[i].ovf});
      chk($sformatf("vec%0d_iszero", i),   {63'd0, bus.iszero},      {63'd0, vecs[i].z});
    end

    // Result must hold while idle.
    repeat (3) @(negedge clk);
    chk("hold_out", {32'd0, bus.out}, 64'h19999999);
    chk("hold_done_low", {63'd0, bus.done}, 64'd0);

    // mulu with in_valid and operands changing during RUN.
    @(negedge clk);
    bus.ctr = 4'd10; bus.input1 = 32'hFFFFFFFF; bus.input2 = 32'hFFFFFFFF; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.ctr = 4'd0; bus.input1 = 32'd1; bus.input2 = 32'd2;
    busy_cnt = 0; nr_cnt = 0; n = 0;
    do begin
      @(negedge clk);
      n++;
      busy_cnt += int'(bus.busy);
      nr_cnt   += int'(!bus.in_ready);
    end while (!bus.done && n < 100);
    bus.in_valid = 1'b0;
    chk("run_latency",    n,        33);
    chk("run_busy_count", busy_cnt, 32);
    chk("run_notready",   nr_cnt,   32);
    chk("run_out",        {32'd0, bus.out},    64'h1);
    chk("run_out_hi",     {32'd0, bus.out_hi}, 64'hFFFFFFFE);
    @(negedge clk);
    chk("run_no_extra_done", {63'd0, bus.done}, 64'd0);
    chk("run_out_held",   {32'd0, bus.out},    64'h1);

    // Reset during RUN aborts with no done pulse.
    @(negedge clk);
    bus.ctr = 4'd10; bus.input1 = 32'd3; bus.input2 = 32'd4; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_busy_before", {63'd0, bus.busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_out",      {32'd0, bus.out},      64'd0);
    chk("abort_out_hi",   {32'd0, bus.out_hi},   64'd0);
    chk("abort_busy",     {63'd0, bus.busy},     64'd0);
    chk("abort_done",     {63'd0, bus.done},     64'd0);
    chk("abort_iszero",   {63'd0, bus.iszero},   64'd1);
    chk("abort_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      done_seen += int'(bus.done);
    end
    chk("abort_no_done", done_seen, 0);
    run_op(4'd0, 32'd2, 32'd3, lat);
    chk("post_reset_add_latency", lat, 1);
    chk("post_reset_add_out", {32'd0, bus.out}, 64'd5);

    // slt then sltu back-to-back, second accepted in DONE.
    @(negedge clk);
    bus.ctr = 4'd5; bus.input1 = 32'hFFFFFFFF; bus.input2 = 32'd1; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_done1", {63'd0, bus.done}, 64'd1);
    chk("b2b_slt",   {32'd0, bus.out},  64'd1);
    chk("b2b_ready_in_done", {63'd0, bus.in_ready}, 64'd1);
    bus.ctr = 4'd6;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("b2b_done2",  {63'd0, bus.done},   64'd1);
    chk("b2b_sltu",   {32'd0, bus.out},    64'd0);
    chk("b2b_iszero", {63'd0, bus.iszero}, 64'd1);
    @(negedge clk);
    chk("b2b_done_drop", {63'd0, bus.done}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
